button_conditioner: RTL

Front-end for the PWM duty-adjust block. It conditions two raw push-button inputs into clean single-cycle inc/dec pulses, with hold-to-repeat. Each channel has a 2-flop synchronizer, a debounce filter, and a repeat timer FSM. Outputs drive the PWM block's inc/dec inputs directly; that block edge-detects them, so every pulse is followed by at least one low cycle.

---
 rtl/button_conditioner.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Sync + debounce + hold-to-repeat for the inc/dec push-buttons.
// Revision : 1.0  initial release
// ============================================================================
module button_conditioner #(
  parameter int              CNT_W        = 16,
  parameter logic [CNT_W-1:0] DEB_CYCLES   = 16'd1000,
  parameter bit              REPEAT_EN    = 1'b1,
  parameter logic [CNT_W-1:0] REPEAT_DELAY = 16'd50000,
  parameter logic [CNT_W-1:0] REPEAT_RATE  = 16'd10000
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic inc,
  output logic dec,
  output logic inc_held,
  output logic dec_held
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_hold   = 2'd1;
  localparam logic [1:0] c_repeat = 2'd2;

  localparam logic [CNT_W-1:0] c_deb_last   = DEB_CYCLES   - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_delay_load = REPEAT_DELAY - CNT_W'(1);
  localparam logic [CNT_W-1:0] c_rate_load  = REPEAT_RATE  - CNT_W'(1);

  // Channel 0 = increment, channel 1 = decrement.
  logic [1:0] w_raw;
  logic [1:0] w_db;
  logic [1:0] w_req;
  logic [1:0] r_pulse;

  assign w_raw = {btn_dec_raw, btn_inc_raw};

  genvar ch;
  generate
    for (ch = 0; ch < 2; ch++) begin : g_ch
      logic             r_sync1;
      logic             r_sync2;
      logic             r_db;
      logic [CNT_W-1:0] r_deb_cnt;
      logic [1:0]       r_state;
      logic [1:0]       w_next_state;
      logic [CNT_W-1:0] r_timer;
      logic [CNT_W-1:0] w_next_timer;
      logic             w_req_ch;

      always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= w_raw[ch];
          r_sync2 <= r_sync1;
        end
      end

      always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
          r_db      <= 1'b0;
          r_deb_cnt <= '0;
        end else if (r_sync2 == r_db) begin
          r_deb_cnt <= '0;
        end else if (r_deb_cnt == c_deb_last) begin
          r_db      <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + CNT_W'(1);
        end
      end

      always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
          r_state <= c_idle;
          r_timer <= '0;
        end else begin
          r_state <= w_next_state;
          r_timer <= w_next_timer;
        end
      end

      // IDLE with db high can only mean a fresh rising edge: any fall returns here.
      always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer;
        if (!r_db) begin
          w_next_state = c_idle;
        end else begin
          case (r_state)
            c_idle: begin
              w_next_state = c_hold;
              w_next_timer = c_delay_load;
            end
            c_hold: begin
              if (REPEAT_EN) begin
                if (r_timer == '0) begin
                  w_next_state = c_repeat;
                  w_next_timer = c_rate_load;
                end else begin
                  w_next_timer = r_timer - CNT_W'(1);
                end
              end
            end
            c_repeat: begin
              if (r_timer == '0) begin
                w_next_timer = c_rate_load;
              end else begin
                w_next_timer = r_timer - CNT_W'(1);
              end
            end
            default: w_next_state = c_idle;
          endcase
        end
      end

      always_comb begin
        w_req_ch = 1'b0;
        if (r_db) begin
          case (r_state)
            c_idle:   w_req_ch = 1'b1;
            c_hold:   w_req_ch = REPEAT_EN && (r_timer == '0);
            c_repeat: w_req_ch = (r_timer == '0);
            default:  w_req_ch = 1'b0;
          endcase
        end
      end

      assign w_db[ch]  = r_db;
      assign w_req[ch] = w_req_ch;
    end
  endgenerate

  // A request only makes it out while the opposite button is released.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_pulse <= 2'b00;
    end else begin
      r_pulse <= {w_req[1] & ~w_db[0], w_req[0] & ~w_db[1]};
    end
  end

  assign inc      = r_pulse[0];
  assign dec      = r_pulse[1];
  assign inc_held = w_db[0];
  assign dec_held = w_db[1];

endmodule
`default_nettype wire
